// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared constants and types for the CPU serial output port
package cpu_io_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_ACTIVE = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is taken when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_uart_tx.sv
// rtl/cpu_uart_tx.sv - bus-written byte FIFO serialised onto an 8N1 LSB-first UART line
module cpu_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic       rd_en_i,
  input  logic       addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     rdata_q, rdata_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [PW:0]    fifo_count;
  logic           baud_last;
  logic [7:0]     status_word;

  assign fifo_push = wr_en_i && (addr_i == ADDR_DATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wdata_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the next state so tx changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    status_word            = 8'h00;
    status_word[ST_OVF]    = ovf_q;
    status_word[ST_EMPTY]  = fifo_empty;
    status_word[ST_FULL]   = fifo_full;
    status_word[ST_ACTIVE] = (state_q != IDLE);

    rdata_d = rdata_q;
    if (rd_en_i) begin
      rdata_d = (addr_i == ADDR_STATUS) ? status_word : 8'h00;
    end

    ovf_d = ovf_q;
    if (rd_en_i && (addr_i == ADDR_STATUS)) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign tx_o    = tx_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_cpu_uart_tx.sv
// tb/tb_cpu_uart_tx.sv - scoreboard bench: occupancy/frame-timer model, UART line decoder, status read monitor
module tb_cpu_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       tx, busy;

  cpu_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .wr_en_i (wr_en),
    .rd_en_i (rd_en),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes waiting in the FIFO, cycles left in the frame on the line, sticky overflow.
  int         m_cnt = 0;
  int         m_rem = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] rd_exp[$];
  int         start_q[$];
  int         cyc = 0;
  int         epoch = 0;
  bit         mon_en = 1'b0;
  logic       rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic model_edge(input logic we, input logic re, input logic a, input logic [7:0] d);
    logic pop;
    logic drop;
    if (re) rd_exp.push_back(a ? {4'b0, m_ovf, (m_cnt == 0), (m_cnt == DEPTH), (m_rem > 0)} : 8'h00);
    pop  = (m_cnt > 0) && (m_rem <= 1);
    drop = 1'b0;
    if (pop) m_cnt--;
    if (we && !a) begin
      if (m_cnt < DEPTH) begin
        m_cnt++;
        exp_tx.push_back(d);
      end else begin
        drop = 1'b1;
      end
    end
    if (re && a) m_ovf = 1'b0;
    if (drop)    m_ovf = 1'b1;
    if (pop) begin
      m_rem = 10 * CPB;
      start_q.push_back(cyc);
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  task automatic step(input logic we, input logic re, input logic a, input logic [7:0] d);
    wr_en = we;
    rd_en = re;
    addr  = a;
    wdata = d;
    @(posedge clk);
    cyc++;
    model_edge(we, re, a, d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    cyc++;
    m_cnt = 0;
    m_rem = 0;
    m_ovf = 1'b0;
    exp_tx.delete();
    start_q.delete();
    rd_exp.delete();
    epoch++;
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_rem > 0 || m_cnt > 0) && n < 2000) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    if (n >= 2000) fail_now("drain_timeout");
    idle(5);
  endtask

  always @(posedge clk) rd_seen <= rd_en && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0) || (m_cnt > 0)});
      if (m_rem == 0) chk("tx_idle_high", {31'b0, tx}, 32'd1);
      if (rd_seen) begin
        if (rd_exp.size() == 0) fail_now("unexpected_read_data");
        else chk("rdata", {24'b0, rdata}, {24'b0, rd_exp.pop_front()});
      end
    end
  end

  // Line decoder: samples each bit in its middle and scores the byte against the accepted-byte queue.
  initial begin
    int         ep;
    logic       sb, stp;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        ep = epoch;
        if (start_q.size() == 0) fail_now("unexpected_frame");
        else chk("start_time", cyc, start_q.pop_front());
        repeat (CPB / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
        if (ep == epoch) begin
          chk("start_bit", {31'b0, sb}, 32'd0);
          chk("stop_bit", {31'b0, stp}, 32'd1);
          if (exp_tx.size() == 0) fail_now("frame_without_expected_byte");
          else chk("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
        end
      end
    end
  end

  initial begin
    int n;
    int found;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = 1'b0;
    wdata = 8'h00;
    do_reset();
    do_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("idle_rdata", {24'b0, rdata}, 32'h0);
    end
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("reset_status", {24'b0, rdata}, 32'h04);

    step(1'b1, 1'b0, 1'b0, 8'h41);
    n = cyc;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      if (!busy) begin
        found = 1;
        break;
      end
    end
    if (found == 0) fail_now("busy_fall_timeout");
    else chk("busy_fall_latency", cyc - n, 32'd41);

    step(1'b1, 1'b0, 1'b0, 8'h48);
    step(1'b1, 1'b0, 1'b0, 8'h49);
    idle(100);

    for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, 1'b0, 8'(k));
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("overflow_status", {24'b0, rdata}, 32'h0B);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("overflow_cleared", {31'b0, rdata[3]}, 32'd0);
    drain();

    step(1'b1, 1'b0, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 1'b0, 8'hC2);
    idle(4 * CPB);
    do_reset();
    chk("abort_tx_high", {31'b0, tx}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("abort_status", {24'b0, rdata}, 32'h04);
    idle(120);

    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h10 + 8'(k));
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_rem == 1 && m_cnt == DEPTH) begin
        found = 1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end
    if (found == 0) fail_now("full_pop_window_timeout");
    step(1'b1, 1'b0, 1'b0, 8'h99);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("pop_write_status", {24'b0, rdata}, 32'h03);
    drain();

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    drain();
    idle(50);
    chk("all_bytes_seen", exp_tx.size(), 32'd0);
    chk("all_frames_seen", start_q.size(), 32'd0);
    chk("all_reads_seen", rd_exp.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_uart_tx.md
# cpu_uart_tx

Memory-mapped serial output port for the 8-bit CPU: the CPU writes bytes into a small FIFO over its data-bus write strobe, and the block serialises them onto a single UART line (8N1, LSB first). It lets programs emit characters that external equipment or a bench-side decoder can capture. A status register tells software when the port is busy, full or has dropped data.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4, byte entries; power of two, ≥ 2.
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high.
- wr_en  input  1  bus write strobe, one transfer per cycle.
- rd_en  input  1  bus read strobe.
- addr  input  1  0 = DATA (write-only), 1 = STATUS (read-only).
- wdata  input  8  write data.
- rdata  output  8  registered read data.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever state ≠ IDLE or the FIFO is non-empty.

## Operation
- Write with addr=0: byte pushed if FIFO not full; if full, the byte is dropped and sticky `overflow` is set.
- Write with addr=1: ignored.
- Read with addr=1 returns {4'b0, overflow, fifo_empty, fifo_full, tx_active}; the read clears `overflow`. Read with addr=0 returns 8'h00.
- If a read that clears `overflow` and a dropped write occur in the same cycle, `overflow` ends set.
- If the FIFO is full and a pop happens in the same cycle as a write, the write is accepted and the count is unchanged.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit index runs 0→7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Width rules:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is one bit wider than the pointers.
- Reset (any time, including mid-frame): state IDLE; FIFO emptied; frame aborted; tx=1 on the next cycle.

## Timing
- Reset values: tx=1, rdata=8'h00, busy=0, overflow=0, FIFO empty.
- rdata is valid the cycle after the edge that sampled rd_en. It holds its value when rd_en is low.
- A write sampled at edge N enters the FIFO at edge N. With the transmitter in IDLE, the pop occurs at edge N+1 and tx falls after edge N+1, giving 1 cycle from FIFO non-empty to start bit.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have zero gap.
- tx is driven from a flop, with no combinational path from the inputs.
- busy rises after the write edge and falls after the last stop-bit cycle when the FIFO is empty.

## Structure
- Package `cpu_io_pkg` holds:
  - address constants ADDR_DATA and ADDR_STATUS;
  - status bit indices ST_ACTIVE=0, ST_FULL=1, ST_EMPTY=2, ST_OVF=3;
  - `uart_tx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides push/pop/full/empty/count. The FSM, baud counter and bus decode live in the top module.

## Test plan
- Reset then idle, CLKS_PER_BIT=4: tx=1, rdata=0, busy=0 for 20 cycles. A STATUS read returns 8'h04.
- Write 8'h41 at edge N: tx=0 over cycles N+1..N+4, then bit sequence 1,0,0,0,0,0,1,0 (4 cycles each), stop high 4 cycles. busy drops at N+41.
- Write 8'h48, 8'h49 on consecutive cycles: two frames back-to-back, second start bit immediately after the first stop bit (80 cycles total). Decoded bytes are 8'h48, 8'h49.
- Six writes 8'h01..8'h06 in six consecutive cycles, FIFO_DEPTH=4:
  - first byte is popped at the cycle after it enters, so five bytes are accepted (8'h01..8'h05);
  - 8'h06 is dropped and the STATUS read returns 8'h0B (overflow, full, active);
  - a second STATUS read shows bit 3 cleared;
  - the line carries 8'h01..8'h05 only.
- Assert reset midway through the DATA bits of 8'hA5 with 2 bytes queued: tx=1 the next cycle, STATUS reads 8'h04, and no further frames follow.
- Pulse a FIFO pop and a write in the same cycle while full: count unchanged, overflow stays 0, and the new byte transmits in order.
